// File: rtl/gpio_ctrl.sv
// GPIO pad-side stage: registered pad drive, synchronised and debounced pad inputs,
// and masked pin-change pending bits folded into one level interrupt for the core.
module gpio_ctrl #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rf_gpio_datareg,
  input  logic [WIDTH-1:0] rf_gpio_tristate,
  input  logic [WIDTH-1:0] rf_gpio_interrupt_mask,
  input  logic [WIDTH-1:0] irq_clear,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic [WIDTH-1:0] ro_gpio_pinstate,
  output logic [WIDTH-1:0] irq_pending,
  output logic             ext_interrupt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]                  gpio_out_reg;
  logic [WIDTH-1:0]                  gpio_oe_reg;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  sync_out;
  logic [WIDTH-1:0]                  pinstate;
  logic [WIDTH-1:0]                  change;
  logic [WIDTH-1:0]                  pending_reg;
  logic [WIDTH-1:0]                  pending_next;
  logic                              ext_interrupt_reg;

  // Pad drive is registered so the register file never reaches the pads combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out_reg <= '0;
      gpio_oe_reg  <= '0;
    end else begin
      gpio_out_reg <= rf_gpio_datareg;
      gpio_oe_reg  <= ~rf_gpio_tristate;
    end
  end

  // Pads are sampled whether driven or not, so a driven pin reads back its own level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio_in};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pin
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             pin_reg;
      logic             pin_next;
      logic             change_bit;

      // Any return to the accepted level restarts the stability count.
      always_comb begin
        cnt_next   = cnt_reg;
        pin_next   = pin_reg;
        change_bit = 1'b0;
        if (sync_out[gi] == pin_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          pin_next   = sync_out[gi];
          cnt_next   = '0;
          change_bit = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
          pin_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          pin_reg <= pin_next;
        end
      end

      assign pinstate[gi] = pin_reg;
      assign change[gi]   = change_bit;
    end
  endgenerate

  // A new event outranks a same-cycle clear so nothing is lost; masked events are dropped.
  always_comb begin
    pending_next = (pending_reg & ~irq_clear) | (change & rf_gpio_interrupt_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg       <= '0;
      ext_interrupt_reg <= 1'b0;
    end else begin
      pending_reg       <= pending_next;
      ext_interrupt_reg <= |(pending_reg & rf_gpio_interrupt_mask);
    end
  end

  assign gpio_out         = gpio_out_reg;
  assign gpio_oe          = gpio_oe_reg;
  assign ro_gpio_pinstate = pinstate;
  assign irq_pending      = pending_reg;
  assign ext_interrupt    = ext_interrupt_reg;

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- GPIO pad-side stage directly downstream of the register file.
- Drives the pad output and output-enable from `rf_gpio_datareg` and `rf_gpio_tristate`.
- Synchronises and debounces pad inputs, and returns the filtered state as `ro_gpio_pinstate`.
- Latches masked pin-change events into per-pin pending bits and produces a single interrupt line for `vscale_core` `ext_interrupts[0]`.

Parameters:
- WIDTH, 16, number of GPIO pins.
- SYNC_STAGES, 2, flops in each input synchroniser chain; minimum 2.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a new level; minimum 1.
- CNT_W, 3, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- rf_gpio_datareg  in  WIDTH  output value per pin.
- rf_gpio_tristate  in  WIDTH  1 = pin is high-Z (input), 0 = pin driven.
- rf_gpio_interrupt_mask  in  WIDTH  1 = pin-change interrupt enabled.
- irq_clear  in  WIDTH  one-cycle write-1-to-clear strobe for pending bits.
- gpio_in  in  WIDTH  raw asynchronous pad input.
- gpio_out  out  WIDTH  pad output value.
- gpio_oe  out  WIDTH  pad output enable, 1 = drive.
- ro_gpio_pinstate  out  WIDTH  debounced pin level, to the register file.
- irq_pending  out  WIDTH  latched pin-change events.
- ext_interrupt  out  1  interrupt request to the core.

Behaviour:
- Reset (reset=0, asynchronous):
  - gpio_out=0; gpio_oe=0, so all pins are inputs.
  - ro_gpio_pinstate=0, irq_pending=0, ext_interrupt=0.
  - All synchroniser flops and debounce counters are cleared to 0.
- Output path:
  - gpio_out <= rf_gpio_datareg and gpio_oe <= ~rf_gpio_tristate on every clk edge.
  - Latency is 1 cycle; no combinational path from register inputs to pads.
- Input sampling:
  - gpio_in is sampled regardless of gpio_oe, so a driven pin reads back its pad level.
  - Each bit passes through SYNC_STAGES flops; the chain output is s[i].
- Debounce, independent per pin, with counter cnt[i]:
  - If s[i] == pinstate[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: pinstate[i] <= s[i], cnt <= 0, and change[i] asserts for that single cycle.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised samples never changes pinstate; the counter restarts on any return to the old level.
  - With DEBOUNCE_CYCLES=1, pinstate follows s[i] one edge later.
  - Total pad-to-pinstate latency is SYNC_STAGES + DEBOUNCE_CYCLES clk edges, 6 with defaults.
- Pending, per pin:
  - irq_pending[i] <= (irq_pending[i] & ~irq_clear[i]) | (change[i] & rf_gpio_interrupt_mask[i]).
  - Both rising and falling accepted changes set the bit.
  - Simultaneous set and clear: set wins, so no event is lost.
  - Changes on masked pins are discarded, not deferred.
  - Clearing the mask does not clear an existing pending bit.
- Interrupt:
  - ext_interrupt <= |(irq_pending & rf_gpio_interrupt_mask), registered.
  - Asserts 1 cycle after the pending bit sets.
  - Deasserts 1 cycle after the last enabled pending bit clears or its mask drops.
  - Level-sensitive; held until software clears.
- Power-up: a pad that is high when reset releases is accepted as a 0→1 change after the full latency and sets pending if masked-in. This is intended; software clears it at init.
- Reset asserted mid-debounce or mid-synchronisation discards all in-flight state immediately.

Test Plan:
1. Reset release with gpio_in=0, tristate=FFFF → gpio_oe=0000, gpio_out=0000, pinstate=0000, pending=0000, ext_interrupt=0 throughout.
2. datareg=A5A5, tristate=00FF → next edge gpio_out=A5A5, gpio_oe=FF00; no change before that edge.
3. mask=0001; gpio_in[0] 0→1 held → pinstate[0]=1 exactly 6 edges after the first sampling edge; pending[0]=1 on the same edge; ext_interrupt=1 one edge later. irq_clear=0001 pulse → pending[0]=0, ext_interrupt=0 the following edge.
4. gpio_in[3] high for 3 cycles then low, mask=0008 → pinstate[3] stays 0, pending stays 0. Repeat with a 4-sample-stable pulse → pinstate[3] rises then falls, pending[3]=1.
5. Pin 5 accepted change on the same edge as irq_clear[5]=1, with pending[5] already set → pending[5] remains 1. Pin 6 change with mask[6]=0 → pending[6]=0, ext_interrupt unaffected.
6. reset asserted 2 edges into a pin-1 debounce → all outputs 0 immediately. After release with gpio_in[1] still high → pinstate[1] rises a full 6 edges later, not earlier.
